// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: serialises one DATA_WIDTH-bit word per tx_strobe,
// LSB first, with busy/done/overrun status for a polling CPU.

package arch_defs_pkg;
    parameter int unsigned DATA_WIDTH = 8;
endpackage

module uart_transmitter #(
    parameter int unsigned CLOCK_SPEED = 20_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_WIDTH  = arch_defs_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_strobe,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear_overrun,
    output logic                  tx_serial_out,
    output logic                  tx_busy,
    output logic                  tx_done_strobe,
    output logic                  tx_overrun
);

    localparam int unsigned CPB   = CLOCK_SPEED / BAUD_RATE;
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;

    logic bit_end;
    assign bit_end = (baud_cnt_q == CNT_W'(CPB - 1));

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_strobe) begin
                    shift_d    = data_in;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = DATA;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                    // Line is loaded one cycle ahead so it comes straight from tx_q.
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_d[0];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);

        // Set beats clear when a dropped request and a clear coincide.
        overrun_d = overrun_q;
        if (clear_overrun)
            overrun_d = 1'b0;
        if (tx_strobe && busy_q)
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_serial_out  = tx_q;
    assign tx_busy        = busy_q;
    assign tx_done_strobe = done_q;
    assign tx_overrun     = overrun_q;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter: serialises one DATA_WIDTH-bit word per request into an 8N1 frame (one start bit, data LSB first, one stop bit) on a single output line. It is the TX counterpart of the peripheral UART receiver, uses the same CLOCK_SPEED/BAUD_RATE parameterisation and sits on the same peripheral bus. The CPU-facing side writes a byte with a one-cycle strobe and polls busy/overrun status.

## Interface
- CLOCK_SPEED, 20_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate in bits per second.
- DATA_WIDTH, from arch_defs_pkg (8): data bits per frame.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- tx_strobe  input  1  one-cycle request to send data_in.
- data_in  input  DATA_WIDTH  word to send; sampled only in the accepting cycle.
- clear_overrun  input  1  one-cycle clear of tx_overrun.
- tx_serial_out  output  1  serial line, idle high, registered.
- tx_busy  output  1  high while a frame is in progress.
- tx_done_strobe  output  1  one-cycle pulse at end of each frame.
- tx_overrun  output  1  sticky: request arrived while busy.

## Operation
- CYCLES_PER_BIT = CLOCK_SPEED / BAUD_RATE (integer division; 2083 at defaults); must be >= 2. Baud counter width $clog2(CYCLES_PER_BIT); bit counter width $clog2(DATA_WIDTH)+1.
- Reset values: tx_serial_out=1, tx_busy=0, tx_done_strobe=0, tx_overrun=0, state=IDLE, counters=0, shift register=0.
- States: IDLE, START, DATA, STOP.
  - IDLE: line 1. tx_strobe=1 -> latch data_in into shift register, clear counters, go START.
  - START: line 0 for CYCLES_PER_BIT cycles -> DATA.
  - DATA: line = shift_reg[0]; every CYCLES_PER_BIT cycles shift right, increment bit counter; after DATA_WIDTH bits -> STOP.
  - STOP: line 1 for CYCLES_PER_BIT cycles -> IDLE, pulse tx_done_strobe.
- Illegal/unreachable state -> IDLE with line 1.
- tx_busy = (state != IDLE), registered with the state.
- tx_strobe while tx_busy=1: request dropped, frame in flight unaffected, tx_overrun set to 1.
- clear_overrun=1 clears tx_overrun; if a dropped request and clear_overrun coincide, set wins (tx_overrun=1).
- data_in changes after acceptance have no effect on the frame in flight.
- Reset (reset=0) mid-frame: abort immediately; next cycle all outputs at reset values, no tx_done_strobe.

## Timing
- tx_strobe high in cycle k (IDLE) -> tx_serial_out=0 and tx_busy=1 from cycle k+1.
- Each bit held exactly CYCLES_PER_BIT cycles; data bit i occupies cycles k+1+(i+1)*CPB .. k+(i+2)*CPB.
- Stop bit occupies cycles k+1+(DATA_WIDTH+1)*CPB .. k+(DATA_WIDTH+2)*CPB.
- Cycle k+1+(DATA_WIDTH+2)*CPB: state IDLE, tx_busy=0, tx_done_strobe=1 (one cycle only), line 1.
- tx_strobe in that same done cycle is accepted (not overrun); next start bit begins the following cycle. Minimum inter-frame gap: one idle cycle beyond the stop bit.
- Frame length: (DATA_WIDTH+2)*CPB cycles (10*CPB at DATA_WIDTH=8).
- tx_serial_out is glitch-free (driven directly from a flop).

## Test plan
Bench uses CLOCK_SPEED=160, BAUD_RATE=10 (CPB=16).
- Reset: hold reset=0 for 3 cycles with tx_strobe toggling -> tx_serial_out=1, tx_busy=0, tx_done_strobe=0, tx_overrun=0 throughout and after release.
- Single frame: tx_strobe with data_in=0xA5 -> line samples at bit centres 0,1,0,1,0,0,1,0,1,1; each level lasts exactly 16 cycles; tx_busy high for 160 cycles; one tx_done_strobe in cycle 161 after acceptance.
- Back-to-back: send 0x00, then strobe 0xFF in the tx_done_strobe cycle -> start bit of second frame one cycle after done; second frame is 0 followed by eight 1s and stop 1; tx_overrun stays 0.
- Overrun: strobe 0x3C, strobe 0x81 at cycle 50 of the frame -> 0x3C frame sent intact, 0x81 never appears, tx_overrun=1 until clear_overrun pulse, then 0; coincident clear and overrun leaves tx_overrun=1.
- Data hold: change data_in to 0x00 one cycle after accepting 0xC3 -> line still carries 0xC3 (1,1,0,0,0,0,1,1 LSB first).
- Reset mid-frame: assert reset=0 during data bit 3 of 0x55 -> next cycle line=1, tx_busy=0, no tx_done_strobe; a new strobe after release sends a complete correct frame.
